// File: rtl/spi_pkg.sv
// Shared SPI definitions: responder FSM states, default word format and the
// mode-0 edge roles also used by the SPI master.
package spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_SHIFT
  } state_e;

  localparam int         DEF_DATA_W    = 8;
  localparam logic [7:0] DEF_IDLE_BYTE = 8'hFF;

  // Mode 0: CPOL=0, CPHA=0 -> sample on SCLK rise, launch on SCLK fall.
  localparam bit SPI_CPOL       = 1'b0;
  localparam bit SPI_CPHA       = 1'b0;
  localparam bit SAMPLE_ON_RISE = (SPI_CPOL == SPI_CPHA);

endpackage

// File: rtl/spi_slave_core_if.sv
// FIFO-side handshake of the SPI responder: RX push port and TX pop port.
// The core is the master (it issues wr_en/rd_en); the FIFOs are the slave.
interface spi_slave_core_if #(
  parameter int DATA_W = spi_pkg::DEF_DATA_W
);
  logic              rx_wr_en;
  logic [DATA_W-1:0] rx_wr_data;
  logic              rx_full;
  logic              tx_rd_en;
  logic [DATA_W-1:0] tx_rd_data;
  logic              tx_empty;

  modport master (
    output rx_wr_en, rx_wr_data, tx_rd_en,
    input  rx_full, tx_rd_data, tx_empty
  );

  modport slave (
    input  rx_wr_en, rx_wr_data, tx_rd_en,
    output rx_full, tx_rd_data, tx_empty
  );
endinterface

// File: rtl/spi_in_sync.sv
// Multi-flop synchroniser for one asynchronous SPI pin, with rise/fall
// detection between the last two stages.
module spi_in_sync #(
  parameter int SYNC_STAGES = 2,
  parameter bit RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  // Bit 0 is the first stage; bit SYNC_STAGES-1 is the oldest sample.
  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], din};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  =  sync_q[SYNC_STAGES-2] & ~sync_q[SYNC_STAGES-1];
  assign fall  = ~sync_q[SYNC_STAGES-2] &  sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/spi_slave_core.sv
// Mode-0 SPI responder: oversamples the SPI pins, pushes received words into
// the RX FIFO and shifts TX FIFO words (or IDLE_BYTE) out on MISO.
module spi_slave_core
  import spi_pkg::*;
#(
  parameter int                DATA_W      = DEF_DATA_W,
  parameter int                SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0] IDLE_BYTE   = DEF_IDLE_BYTE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spi_sclk,
  input  logic              spi_cs_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  spi_slave_core_if.master  fifo,
  output logic              busy,
  output logic              rx_overrun,
  output logic              tx_underrun
);

  localparam int              CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
  // Pin order {mosi, cs_n, sclk}; cs_n idles high so its chain resets to 1.
  localparam logic [2:0]      SYNC_RST = 3'b010;

  logic [2:0] pin_raw, pin_lvl, pin_rise, pin_fall;

  assign pin_raw = {spi_mosi, spi_cs_n, spi_sclk};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_sync
      spi_in_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .RST_VAL     (SYNC_RST[gi])
      ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (pin_raw[gi]),
        .level (pin_lvl[gi]),
        .rise  (pin_rise[gi]),
        .fall  (pin_fall[gi])
      );
    end
  endgenerate

  logic sample_edge, launch_edge, cs_rise, cs_fall, mosi_s;
  logic unused_sync;

  assign sample_edge = SAMPLE_ON_RISE ? pin_rise[0] : pin_fall[0];
  assign launch_edge = SAMPLE_ON_RISE ? pin_fall[0] : pin_rise[0];
  assign cs_rise     = pin_rise[1];
  assign cs_fall     = pin_fall[1];
  assign mosi_s      = pin_lvl[2];
  assign unused_sync = &{1'b0, pin_lvl[1:0], pin_rise[2], pin_fall[2]};

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] rx_sr_q, rx_sr_d;
  logic [DATA_W-1:0] tx_sr_q, tx_sr_d;
  logic [DATA_W-1:0] tx_next_q, tx_next_d;
  logic              pend_q, pend_d;        // tx_next must replace tx_sr on next launch edge
  logic              cap_q, cap_d;          // FIFO read data lands this cycle
  logic              use_idle_q, use_idle_d;
  logic              rx_wr_en_q, rx_wr_en_d;
  logic [DATA_W-1:0] rx_wr_data_q, rx_wr_data_d;
  logic              tx_rd_en_c, tx_underrun_c, rx_overrun_c;
  logic [DATA_W-1:0] rx_word;

  assign rx_word = {rx_sr_q[DATA_W-2:0], mosi_s};

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    rx_sr_d       = rx_sr_q;
    tx_sr_d       = tx_sr_q;
    tx_next_d     = tx_next_q;
    pend_d        = pend_q;
    cap_d         = 1'b0;
    use_idle_d    = use_idle_q;
    rx_wr_en_d    = 1'b0;
    rx_wr_data_d  = rx_wr_data_q;
    tx_rd_en_c    = 1'b0;
    tx_underrun_c = 1'b0;
    rx_overrun_c  = 1'b0;

    if (cap_q) begin
      tx_next_d = use_idle_q ? IDLE_BYTE : fifo.tx_rd_data;
    end

    if (cs_rise) begin
      state_d   = ST_IDLE;
      bit_cnt_d = '0;
      pend_d    = 1'b0;
      tx_sr_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (cs_fall) begin
            state_d = ST_FETCH;
          end
        end
        ST_FETCH: begin
          tx_rd_en_c    = !fifo.tx_empty;
          tx_underrun_c = fifo.tx_empty;
          use_idle_d    = fifo.tx_empty;
          state_d       = ST_LOAD;
        end
        ST_LOAD: begin
          tx_sr_d   = use_idle_q ? IDLE_BYTE : fifo.tx_rd_data;
          bit_cnt_d = '0;
          pend_d    = 1'b0;
          state_d   = ST_SHIFT;
        end
        ST_SHIFT: begin
          if (sample_edge) begin
            rx_sr_d   = rx_word;
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == LAST_BIT) begin
              rx_wr_en_d    = !fifo.rx_full;
              rx_overrun_c  = fifo.rx_full;
              if (!fifo.rx_full) begin
                rx_wr_data_d = rx_word;
              end
              // Prefetch now so the next word is ready by the following launch edge.
              tx_rd_en_c    = !fifo.tx_empty;
              tx_underrun_c = fifo.tx_empty;
              use_idle_d    = fifo.tx_empty;
              pend_d        = 1'b1;
              cap_d         = 1'b1;
            end
          end else if (launch_edge) begin
            if (pend_q) begin
              tx_sr_d = tx_next_q;
              pend_d  = 1'b0;
            end else begin
              tx_sr_d = tx_sr_q << 1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      bit_cnt_q    <= '0;
      rx_sr_q      <= '0;
      tx_sr_q      <= '0;
      tx_next_q    <= '0;
      pend_q       <= 1'b0;
      cap_q        <= 1'b0;
      use_idle_q   <= 1'b0;
      rx_wr_en_q   <= 1'b0;
      rx_wr_data_q <= '0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      rx_sr_q      <= rx_sr_d;
      tx_sr_q      <= tx_sr_d;
      tx_next_q    <= tx_next_d;
      pend_q       <= pend_d;
      cap_q        <= cap_d;
      use_idle_q   <= use_idle_d;
      rx_wr_en_q   <= rx_wr_en_d;
      rx_wr_data_q <= rx_wr_data_d;
    end
  end

  assign busy            = (state_q != ST_IDLE);
  assign spi_miso        = tx_sr_q[DATA_W-1];
  assign spi_miso_oe     = busy;
  assign fifo.rx_wr_en   = rx_wr_en_q;
  assign fifo.rx_wr_data = rx_wr_data_q;
  assign fifo.tx_rd_en   = tx_rd_en_c;
  assign rx_overrun      = rx_overrun_c;
  assign tx_underrun     = tx_underrun_c;

endmodule
